// File: rtl/mem_arb2to1_if.sv
// rtl/mem_arb2to1_if.sv - mem_req/mem_resp payload types and handshake interface
package mem_arb2to1_pkg;

    typedef struct packed {
        logic [31:0] req_addr;
        logic        req_type;
        logic [3:0]  req_mask;
        logic [31:0] req_data;
        logic [2:0]  req_burst;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] resp_data;
        logic        resp_err;
    } mem_resp_t;

endpackage

interface mem_arb2to1_if;
    import mem_arb2to1_pkg::*;

    logic      req_valid;
    logic      req_ready;
    mem_req_t  req;
    logic      resp_valid;
    logic      resp_ready;
    mem_resp_t resp;

    modport master (
        output req_valid, req, resp_ready,
        input  req_ready, resp_valid, resp
    );

    modport slave (
        input  req_valid, req, resp_ready,
        output req_ready, resp_valid, resp
    );

endinterface

// File: rtl/mem_arb2to1.sv
// rtl/mem_arb2to1.sv - two-master round-robin mem_req arbiter with in-order response routing
module mem_arb2to1
    import mem_arb2to1_pkg::*;
#(
    parameter int OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rstn,
    mem_arb2to1_if.slave    m0,
    mem_arb2to1_if.slave    m1,
    mem_arb2to1_if.master   s,
    output logic            resp_orphan
);

    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING) + 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(OUTSTANDING - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(OUTSTANDING);

    typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

    state_t        state_q, state_d;
    logic          grant_q;
    logic          last_grant_q;
    logic          grant;
    logic          any_req;
    logic          s_valid;
    logic          handshake;

    logic          route_q [2**PW];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          fifo_empty, fifo_full;
    logic          head;
    logic          pop;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_OPEN;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (s_valid && !s.req_ready)
                grant_q <= grant;
            if (handshake)
                last_grant_q <= grant;
        end
    end

    // A stalled request keeps its master and payload until mem2ahb takes it.
    always_comb begin
        grant   = 1'b0;
        any_req = 1'b0;
        state_d = state_q;
        case (state_q)
            ST_OPEN: begin
                any_req = m0.req_valid | m1.req_valid;
                if (m0.req_valid && m1.req_valid)
                    grant = ~last_grant_q;
                else
                    grant = m1.req_valid;
            end
            ST_LOCKED: begin
                any_req = 1'b1;
                grant   = grant_q;
            end
            default: ;
        endcase
        s_valid   = rstn & any_req & ~fifo_full;
        handshake = s_valid & s.req_ready;
        if (handshake)
            state_d = ST_OPEN;
        else if (s_valid)
            state_d = ST_LOCKED;
    end

    assign s.req_valid  = s_valid;
    assign s.req        = !rstn ? '0 : (grant ? m1.req : m0.req);
    assign m0.req_ready = handshake & ~grant;
    assign m1.req_ready = handshake &  grant;

    // Route FIFO: one entry per accepted request, holding the issuing master id.
    always_ff @(posedge clk) begin
        if (handshake)
            route_q[wr_ptr_q] <= grant;
    end

    assign head = route_q[rd_ptr_q];
    assign pop  = s.resp_valid & s.resp_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            resp_orphan <= 1'b0;
        end else begin
            if (handshake)
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            case ({handshake, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (s.resp_valid && fifo_empty)
                resp_orphan <= 1'b1;
        end
    end

    assign s.resp_ready  = ~fifo_empty & (head ? m1.resp_ready : m0.resp_ready);
    assign m0.resp_valid = s.resp_valid & ~fifo_empty & ~head;
    assign m1.resp_valid = s.resp_valid & ~fifo_empty &  head;
    assign m0.resp       = rstn ? s.resp : '0;
    assign m1.resp       = rstn ? s.resp : '0;

endmodule

// File: tb/tb_mem_arb2to1.sv
// tb/tb_mem_arb2to1.sv - directed self-checking bench for mem_arb2to1
module tb_mem_arb2to1;
    import mem_arb2to1_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    logic resp_orphan;
    int   checks = 0;
    int   errors = 0;

    mem_arb2to1_if m0_if ();
    mem_arb2to1_if m1_if ();
    mem_arb2to1_if s_if ();

    mem_arb2to1 #(.OUTSTANDING(2)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .m0          (m0_if.slave),
        .m1          (m1_if.slave),
        .s           (s_if.master),
        .resp_orphan (resp_orphan)
    );

    always #5 clk = ~clk;

    function automatic mem_req_t mk_req(input logic [31:0] addr, input logic wr, input logic [31:0] data);
        mem_req_t r;
        r.req_addr  = addr;
        r.req_type  = wr;
        r.req_mask  = 4'hf;
        r.req_data  = data;
        r.req_burst = 3'd0;
        return r;
    endfunction

    function automatic mem_resp_t mk_resp(input logic [31:0] data);
        mem_resp_t r;
        r.resp_data = data;
        r.resp_err  = 1'b0;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        m0_if.req_valid = 1'b1;
        m1_if.req_valid = 1'b1;
        s_if.req_ready  = 1'b1;
        s_if.resp_valid = 1'b1;
        #2;
        checks++; if (s_if.req_valid !== 1'b0) begin errors++; $display("FAIL reset_s_req_valid got %b exp 0", s_if.req_valid); end
        checks++; if (m0_if.req_ready !== 1'b0) begin errors++; $display("FAIL reset_m0_req_ready got %b exp 0", m0_if.req_ready); end
        checks++; if (m1_if.req_ready !== 1'b0) begin errors++; $display("FAIL reset_m1_req_ready got %b exp 0", m1_if.req_ready); end
        checks++; if (m0_if.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_m0_resp_valid got %b exp 0", m0_if.resp_valid); end
        checks++; if (s_if.resp_ready !== 1'b0) begin errors++; $display("FAIL reset_s_resp_ready got %b exp 0", s_if.resp_ready); end
        checks++; if (resp_orphan !== 1'b0) begin errors++; $display("FAIL reset_orphan got %b exp 0", resp_orphan); end
        m0_if.req_valid = 1'b0;
        m1_if.req_valid = 1'b0;
        s_if.resp_valid = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_m0_only();
        m0_if.req       = mk_req(32'h10, 1'b1, 32'h10);
        m0_if.req_valid = 1'b1;
        s_if.req_ready  = 1'b1;
        #1;
        checks++; if (s_if.req_valid !== 1'b1) begin errors++; $display("FAIL m0only_s_valid got %b exp 1", s_if.req_valid); end
        checks++; if (s_if.req.req_addr !== 32'h10) begin errors++; $display("FAIL m0only_addr got %h exp 10", s_if.req.req_addr); end
        checks++; if (s_if.req.req_data !== 32'h10) begin errors++; $display("FAIL m0only_data got %h exp 10", s_if.req.req_data); end
        checks++; if (m0_if.req_ready !== 1'b1 || m1_if.req_ready !== 1'b0) begin errors++; $display("FAIL m0only_ready got %b%b exp 10", m0_if.req_ready, m1_if.req_ready); end
        tick();
        m0_if.req_valid = 1'b0;
        s_if.resp       = mk_resp(32'h1234);
        s_if.resp_valid = 1'b1;
        #1;
        checks++; if (m0_if.resp_valid !== 1'b1 || m1_if.resp_valid !== 1'b0) begin errors++; $display("FAIL m0only_resp_route got %b%b exp 10", m0_if.resp_valid, m1_if.resp_valid); end
        checks++; if (m0_if.resp.resp_data !== 32'h1234) begin errors++; $display("FAIL m0only_resp_data got %h exp 1234", m0_if.resp.resp_data); end
        checks++; if (s_if.resp_ready !== 1'b1) begin errors++; $display("FAIL m0only_s_resp_ready got %b exp 1", s_if.resp_ready); end
        tick();
        s_if.resp_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        m0_if.req       = mk_req(32'h60, 1'b0, 32'h0);
        m0_if.req_valid = 1'b1;
        #1;
        checks++; if (m0_if.req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_issue got %b exp 1", m0_if.req_ready); end
        tick();
        m0_if.req_valid = 1'b0;
        rstn = 1'b0;
        #1;
        checks++; if (resp_orphan !== 1'b0) begin errors++; $display("FAIL rstmid_orphan got %b exp 0", resp_orphan); end
        tick();
        rstn = 1'b1;
        s_if.resp       = mk_resp(32'hdead);
        s_if.resp_valid = 1'b1;
        #1;
        checks++; if (s_if.resp_ready !== 1'b0) begin errors++; $display("FAIL rstmid_empty_ready got %b exp 0", s_if.resp_ready); end
        checks++; if (m0_if.resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_empty_route got %b exp 0", m0_if.resp_valid); end
        s_if.resp_valid = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        m0_if.req = mk_req(32'h0, 1'b0, 32'h0);
        m1_if.req = mk_req(32'h40, 1'b0, 32'h0);
        m0_if.req_valid = 1'b1;
        m1_if.req_valid = 1'b1;
        s_if.req_ready  = 1'b1;
        #1;
        checks++; if (s_if.req.req_addr !== 32'h0 || m0_if.req_ready !== 1'b1) begin errors++; $display("FAIL rr_c1 got addr %h rdy %b exp 0 1", s_if.req.req_addr, m0_if.req_ready); end
        tick();
        m0_if.req = mk_req(32'h4, 1'b0, 32'h0);
        s_if.resp = mk_resp(32'hd0);
        s_if.resp_valid = 1'b1;
        #1;
        checks++; if (s_if.req.req_addr !== 32'h40 || m1_if.req_ready !== 1'b1) begin errors++; $display("FAIL rr_c2 got addr %h rdy %b exp 40 1", s_if.req.req_addr, m1_if.req_ready); end
        checks++; if (m0_if.resp_valid !== 1'b1 || m1_if.resp_valid !== 1'b0) begin errors++; $display("FAIL rr_resp0 got %b%b exp 10", m0_if.resp_valid, m1_if.resp_valid); end
        tick();
        m1_if.req = mk_req(32'h44, 1'b0, 32'h0);
        s_if.resp = mk_resp(32'hd1);
        #1;
        checks++; if (s_if.req.req_addr !== 32'h4 || m0_if.req_ready !== 1'b1) begin errors++; $display("FAIL rr_c3 got addr %h rdy %b exp 4 1", s_if.req.req_addr, m0_if.req_ready); end
        checks++; if (m1_if.resp_valid !== 1'b1 || m0_if.resp_valid !== 1'b0) begin errors++; $display("FAIL rr_resp1 got %b%b exp 01", m0_if.resp_valid, m1_if.resp_valid); end
        checks++; if (m1_if.resp.resp_data !== 32'hd1) begin errors++; $display("FAIL rr_resp1_data got %h exp d1", m1_if.resp.resp_data); end
        tick();
        m0_if.req_valid = 1'b0;
        s_if.resp = mk_resp(32'hd2);
        #1;
        checks++; if (s_if.req.req_addr !== 32'h44 || m1_if.req_ready !== 1'b1) begin errors++; $display("FAIL rr_c4 got addr %h rdy %b exp 44 1", s_if.req.req_addr, m1_if.req_ready); end
        checks++; if (m0_if.resp_valid !== 1'b1) begin errors++; $display("FAIL rr_resp2 got %b exp 1", m0_if.resp_valid); end
        tick();
        m1_if.req_valid = 1'b0;
        s_if.resp = mk_resp(32'hd3);
        #1;
        checks++; if (s_if.req_valid !== 1'b0) begin errors++; $display("FAIL rr_idle got %b exp 0", s_if.req_valid); end
        checks++; if (m1_if.resp_valid !== 1'b1 || s_if.resp_ready !== 1'b1) begin errors++; $display("FAIL rr_resp3 got %b%b exp 11", m1_if.resp_valid, s_if.resp_ready); end
        tick();
        s_if.resp_valid = 1'b0;
    endtask

    task automatic test_lock();
        m1_if.req       = mk_req(32'h20, 1'b0, 32'h0);
        m1_if.req_valid = 1'b1;
        s_if.req_ready  = 1'b0;
        #1;
        checks++; if (s_if.req_valid !== 1'b1 || s_if.req.req_addr !== 32'h20) begin errors++; $display("FAIL lock_a got v %b addr %h exp 1 20", s_if.req_valid, s_if.req.req_addr); end
        tick();
        m0_if.req       = mk_req(32'h30, 1'b0, 32'h0);
        m0_if.req_valid = 1'b1;
        #1;
        checks++; if (s_if.req.req_addr !== 32'h20) begin errors++; $display("FAIL lock_b got %h exp 20", s_if.req.req_addr); end
        tick();
        #1;
        checks++; if (s_if.req.req_addr !== 32'h20) begin errors++; $display("FAIL lock_c got %h exp 20", s_if.req.req_addr); end
        tick();
        s_if.req_ready = 1'b1;
        #1;
        checks++; if (s_if.req.req_addr !== 32'h20 || m1_if.req_ready !== 1'b1 || m0_if.req_ready !== 1'b0) begin errors++; $display("FAIL lock_hs got addr %h rdy %b%b exp 20 01", s_if.req.req_addr, m0_if.req_ready, m1_if.req_ready); end
        tick();
        m1_if.req_valid = 1'b0;
        #1;
        checks++; if (s_if.req.req_addr !== 32'h30 || m0_if.req_ready !== 1'b1) begin errors++; $display("FAIL lock_next got addr %h rdy %b exp 30 1", s_if.req.req_addr, m0_if.req_ready); end
        tick();
        m0_if.req_valid = 1'b0;
    endtask

    task automatic test_full();
        m1_if.req       = mk_req(32'h50, 1'b0, 32'h0);
        m1_if.req_valid = 1'b1;
        #1;
        checks++; if (s_if.req_valid !== 1'b0 || m1_if.req_ready !== 1'b0) begin errors++; $display("FAIL full_block got %b%b exp 00", s_if.req_valid, m1_if.req_ready); end
        tick();
        checks++; if (s_if.req_valid !== 1'b0) begin errors++; $display("FAIL full_hold got %b exp 0", s_if.req_valid); end
        tick();
        s_if.resp       = mk_resp(32'he0);
        s_if.resp_valid = 1'b1;
        #1;
        checks++; if (s_if.req_valid !== 1'b0) begin errors++; $display("FAIL full_pop_cycle got %b exp 0", s_if.req_valid); end
        checks++; if (m1_if.resp_valid !== 1'b1 || s_if.resp_ready !== 1'b1) begin errors++; $display("FAIL full_pop_route got %b%b exp 11", m1_if.resp_valid, s_if.resp_ready); end
        tick();
        s_if.resp_valid = 1'b0;
        #1;
        checks++; if (s_if.req_valid !== 1'b1 || s_if.req.req_addr !== 32'h50 || m1_if.req_ready !== 1'b1) begin errors++; $display("FAIL full_issue got v %b addr %h rdy %b exp 1 50 1", s_if.req_valid, s_if.req.req_addr, m1_if.req_ready); end
        tick();
        m1_if.req_valid  = 1'b0;
        m0_if.resp_ready = 1'b0;
        s_if.resp        = mk_resp(32'he1);
        s_if.resp_valid  = 1'b1;
        #1;
        checks++; if (m0_if.resp_valid !== 1'b1 || s_if.resp_ready !== 1'b0) begin errors++; $display("FAIL full_bp got %b%b exp 10", m0_if.resp_valid, s_if.resp_ready); end
        tick();
        checks++; if (m0_if.resp_valid !== 1'b1) begin errors++; $display("FAIL full_bp_hold got %b exp 1", m0_if.resp_valid); end
        m0_if.resp_ready = 1'b1;
        #1;
        checks++; if (s_if.resp_ready !== 1'b1) begin errors++; $display("FAIL full_bp_release got %b exp 1", s_if.resp_ready); end
        tick();
        s_if.resp = mk_resp(32'he2);
        #1;
        checks++; if (m1_if.resp_valid !== 1'b1 || m0_if.resp_valid !== 1'b0) begin errors++; $display("FAIL full_drain got %b%b exp 01", m0_if.resp_valid, m1_if.resp_valid); end
        tick();
        s_if.resp_valid = 1'b0;
    endtask

    task automatic test_orphan();
        s_if.resp       = mk_resp(32'hbad);
        s_if.resp_valid = 1'b1;
        #1;
        checks++; if (s_if.resp_ready !== 1'b0 || m0_if.resp_valid !== 1'b0 || m1_if.resp_valid !== 1'b0) begin errors++; $display("FAIL orphan_route got %b%b%b exp 000", s_if.resp_ready, m0_if.resp_valid, m1_if.resp_valid); end
        checks++; if (resp_orphan !== 1'b0) begin errors++; $display("FAIL orphan_pre got %b exp 0", resp_orphan); end
        tick();
        checks++; if (resp_orphan !== 1'b1) begin errors++; $display("FAIL orphan_set got %b exp 1", resp_orphan); end
        s_if.resp_valid = 1'b0;
        tick();
        checks++; if (resp_orphan !== 1'b1 || s_if.resp_ready !== 1'b0) begin errors++; $display("FAIL orphan_sticky got %b%b exp 10", resp_orphan, s_if.resp_ready); end
        rstn = 1'b0;
        #1;
        checks++; if (resp_orphan !== 1'b0) begin errors++; $display("FAIL orphan_clear got %b exp 0", resp_orphan); end
        tick();
        rstn = 1'b1;
        #1;
        checks++; if (resp_orphan !== 1'b0) begin errors++; $display("FAIL orphan_after_rst got %b exp 0", resp_orphan); end
    endtask

    initial begin
        rstn             = 1'b0;
        m0_if.req_valid  = 1'b0;
        m1_if.req_valid  = 1'b0;
        m0_if.req        = '0;
        m1_if.req        = '0;
        m0_if.resp_ready = 1'b1;
        m1_if.resp_ready = 1'b1;
        s_if.req_ready   = 1'b0;
        s_if.resp_valid  = 1'b0;
        s_if.resp        = '0;
        tick();
        test_reset();
        test_m0_only();
        test_reset_mid();
        test_round_robin();
        test_lock();
        test_full();
        test_orphan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arb2to1.md
Name: mem_arb2to1

Overview:
- Two-master to one-slave arbiter on the mem_req/mem_resp protocol.
- Sits directly upstream of mem2ahb. Merges the instruction-fetch port (m0) and the load/store port (m1) into the single mem_req stream that mem2ahb converts to AHB.
- Routes each in-order mem_resp back to the master that issued the matching request.

Parameters:
OUTSTANDING, 2, depth of the route FIFO; maximum number of accepted requests still awaiting a response (power of 2, ≥1)

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
m0_req_valid  input  1  master 0 request valid
m0_req_ready  output  1  master 0 request accepted
m0_req  input  mem_req_t  master 0 request payload (req_addr, req_type, req_mask, req_data, req_burst)
m0_resp_valid  output  1  master 0 response valid
m0_resp_ready  input  1  master 0 response accept
m0_resp  output  mem_resp_t  master 0 response payload
m1_req_valid / m1_req_ready / m1_req / m1_resp_valid / m1_resp_ready / m1_resp  same as m0, for master 1
s_req_valid  output  1  request to mem2ahb
s_req_ready  input  1  mem2ahb accepts request
s_req  output  mem_req_t  muxed request payload
s_resp_valid  input  1  response from mem2ahb
s_resp_ready  output  1  response accepted
s_resp  input  mem_resp_t  response payload
resp_orphan  output  1  sticky error: response arrived with route FIFO empty

Behaviour:
- Reset (rstn low, asynchronous): s_req_valid=0, resp_orphan=0, route FIFO empty (count=0), lock=0, last_grant=1 (so m0 wins the first tie).
- All outputs read 0 during reset, including m*_req_ready and m*_resp_valid.
- Arbitration (lock=0):
  - Candidates are the masters with req_valid=1.
  - With a single candidate, that master wins.
  - With both, the master != last_grant wins (round robin).
  - grant is combinational from the candidates.
- Gating:
  - s_req_valid = (lock ? 1 : any candidate) AND NOT fifo_full.
  - s_req = payload of the granted master.
  - mX_req_ready = (grant==X) AND s_req_valid AND s_req_ready.
- Lock:
  - If s_req_valid=1 and s_req_ready=0 at a clock edge: lock=1 and the grant is registered.
  - While locked, grant and payload source are held regardless of the other master's valid, so the request stays stable until handshake as mem2ahb requires.
  - lock clears on handshake.
- Handshake (s_req_valid & s_req_ready):
  - Push the grant id into the route FIFO.
  - last_grant <= grant.
  - Zero-cycle pass-through: a request can be accepted in the same cycle it is presented.
- FIFO full:
  - s_req_valid is held 0, decided from the registered count at the start of the cycle.
  - A pop in the same cycle does not allow a push.
  - A locked request never sees full: pushes only occur on handshake.
- Response routing:
  - head = FIFO head id.
  - m[head]_resp_valid = s_resp_valid AND NOT empty; the other master's resp_valid = 0.
  - Both m*_resp carry s_resp.
  - s_resp_ready = m[head]_resp_ready AND NOT empty.
  - Pop on s_resp_valid & s_resp_ready.
- Simultaneous push and pop (not full): count unchanged; head advances; the new entry is written at the tail.
- Orphan response:
  - s_resp_valid=1 with FIFO empty sets resp_orphan=1 until reset.
  - The orphan response is not acknowledged (s_resp_ready=0).
- Pointers: read/write pointers wrap modulo OUTSTANDING; count is width clog2(OUTSTANDING)+1.
- Latency: no added cycles on the request or response path; registers hold state only (lock, grant, FIFO).
- Reset mid-transaction: FIFO, lock and grant are cleared; pending responses after reset count as orphans.

Test Plan:
- m0 only: write addr 0x10, data 0x10 → s_req.req_addr=0x10 in the same cycle; the response is seen only on m0_resp_valid; m1_resp_valid stays 0.
- Both valid every cycle (m0 reads 0x0,0x4; m1 reads 0x40,0x44; sram preloaded) → s_req order is m0 0x0, m1 0x40, m0 0x4, m1 0x44; each master receives its own data.
- s_req_ready held 0 for 3 cycles with m1 locked at 0x20; m0 asserts mid-stall → s_req stays at 0x20 from m1 until handshake; m0 is granted next.
- OUTSTANDING=2, responses stalled → third request sees s_req_valid=0 until one response pops; it issues the cycle after the pop.
- Force s_resp_valid=1 with no request issued → resp_orphan=1 and s_resp_ready=0; both stay until rstn.
- Assert rstn=0 with 1 request outstanding → after release, count=0, m0 wins the first tie, resp_orphan=0.
